// File: rtl/lsu_bus_master_pkg.sv
// Shared mem-op encodings, access-size decode and FSM states for the LSU bus master.
package lsu_bus_master_pkg;

  localparam logic [2:0] MEMOP_W   = 3'b000;
  localparam logic [2:0] MEMOP_SH  = 3'b001;
  localparam logic [2:0] MEMOP_SB  = 3'b010;
  localparam logic [2:0] MEMOP_BAD = 3'b011;
  localparam logic [2:0] MEMOP_LH  = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LB  = 3'b110;
  localparam logic [2:0] MEMOP_LBU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_NONE = 2'd3
  } memop_size_t;

  function automatic memop_size_t memop_size(input logic [2:0] op);
    case (op)
      MEMOP_W:                      return SZ_WORD;
      MEMOP_SH, MEMOP_LH, MEMOP_LHU: return SZ_HALF;
      MEMOP_SB, MEMOP_LB, MEMOP_LBU: return SZ_BYTE;
      default:                      return SZ_NONE;
    endcase
  endfunction

  function automatic logic memop_unsigned(input logic [2:0] op);
    return (op == MEMOP_LHU) || (op == MEMOP_LBU);
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Data-memory bus port: the LSU drives the request side, memory returns ack and read data.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment check, byte-enable generation, store lane shift and load extension.
module lsu_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic        bad_op,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  memop_size_t size;
  logic        uns;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size   = memop_size(op);
  assign uns    = memop_unsigned(op);
  assign bad_op = (size == SZ_NONE);

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    case (size)
      SZ_WORD: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: be = 4'b0001 << addr_lo;
      default: be = 4'b0000;
    endcase
  end

  // Each lane picks its source byte by access size; lanes outside the enable mask stay zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src;
      assign src = (size == SZ_WORD) ? wdata[8*gi +: 8] :
                   (size == SZ_HALF) ? wdata[8*(gi%2) +: 8] :
                                       wdata[7:0];
      assign wdata_lane[8*gi +: 8] = be[gi] ? src : 8'h00;
    end
  endgenerate

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = 32'h0;
    case (size)
      SZ_WORD: rdata_ext = rdata;
      SZ_HALF: rdata_ext = {{16{~uns & half_sel[15]}}, half_sel};
      SZ_BYTE: rdata_ext = {{24{~uns & byte_sel[7]}}, byte_sel};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: IDLE/BUS/DONE handshake FSM with registered bus outputs.
// Optional bus-ack timeout enabled with `define LSU_BUS_TIMEOUT_EN.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [2:0]        req_op_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_err_o,
  lsu_bus_master_if.master  mem
);

  lsu_state_t        state_reg;
  logic [2:0]        op_reg;
  logic              we_reg;
  logic [1:0]        addr_lo_reg;
  logic              kill_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [3:0]        mem_be_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              done_reg;
  logic [31:0]       rdata_reg;
  logic              adel_reg;
  logic              ades_reg;

  logic              idle;
  logic [2:0]        al_op;
  logic [1:0]        al_addr_lo;
  logic              misalign;
  logic              bad_op;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;

  // The aligner sees the incoming request while idle and the latched access otherwise.
  assign idle       = (state_reg == ST_IDLE);
  assign al_op      = idle ? req_op_i : op_reg;
  assign al_addr_lo = idle ? req_addr_i[1:0] : addr_lo_reg;

  lsu_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .wdata      (req_wdata_i),
    .rdata      (mem.mem_rdata_i),
    .misalign   (misalign),
    .bad_op     (bad_op),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_reg;
  logic       bus_err_reg;
  assign bus_err_o = bus_err_reg;
`else
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= 3'b000;
      we_reg        <= 1'b0;
      addr_lo_reg   <= 2'b00;
      kill_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'b0000;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'h0;
      done_reg      <= 1'b0;
      rdata_reg     <= 32'h0;
      adel_reg      <= 1'b0;
      ades_reg      <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      wait_cnt_reg  <= 8'h00;
      bus_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i && !kill_i) begin
            op_reg      <= req_op_i;
            we_reg      <= req_we_i;
            addr_lo_reg <= req_addr_i[1:0];
            kill_reg    <= 1'b0;
            if (misalign || bad_op) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              rdata_reg <= 32'h0;
              adel_reg  <= misalign & ~req_we_i;
              ades_reg  <= misalign & req_we_i;
            end else begin
              state_reg     <= ST_BUS;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= req_we_i;
              mem_be_reg    <= be;
              mem_addr_reg  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              mem_wdata_reg <= wdata_lane;
`ifdef LSU_BUS_TIMEOUT_EN
              wait_cnt_reg  <= 8'h00;
`endif
            end
          end
        end

        ST_BUS: begin
          if (mem.mem_ack_i) begin
            mem_req_reg <= 1'b0;
            if (kill_i || kill_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              rdata_reg <= we_reg ? 32'h0 : rdata_ext;
            end
          end else begin
            if (kill_i) kill_reg <= 1'b1;
`ifdef LSU_BUS_TIMEOUT_EN
            if (wait_cnt_reg == TIMEOUT_LAST) begin
              mem_req_reg <= 1'b0;
              if (kill_i || kill_reg) begin
                state_reg <= ST_IDLE;
              end else begin
                state_reg   <= ST_DONE;
                done_reg    <= 1'b1;
                rdata_reg   <= 32'h0;
                bus_err_reg <= 1'b1;
              end
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
`endif
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          rdata_reg <= 32'h0;
          adel_reg  <= 1'b0;
          ades_reg  <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
          bus_err_reg <= 1'b0;
`endif
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = ~idle;
  assign done_o  = done_reg & ~kill_i;
  assign rdata_o = rdata_reg;
  assign adel_o  = adel_reg;
  assign ades_o  = ades_reg;

  assign mem.mem_req_o   = mem_req_reg;
  assign mem.mem_we_o    = mem_we_reg;
  assign mem.mem_be_o    = mem_be_reg;
  assign mem.mem_addr_o  = mem_addr_reg;
  assign mem.mem_wdata_o = mem_wdata_reg;

endmodule
